// File: rtl/mips_prog_loader.sv
// Host-side loader for the pipe_MIPS32 core: streams a program into shared
// memory, releases the core, waits for HLT, then streams a result window out.
module mips_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DUMP_BASE   = 120,
  parameter int DUMP_LEN    = 2,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err
);

  // Both streams: a word moves on a cycle where valid and ready are both high;
  // the sender holds its word stable until that cycle.

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RD_REQ, RD_WAIT, SEND} state_t;

  localparam int                CNT_W    = $clog2(RUN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_LEN - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  run_cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_addr;
  logic              halt_ok;
  logic              run_expire;

  // Window address wraps naturally at the top of memory.
  assign rd_addr = BASE + idx;

  // A halt seen in the first two RUN cycles may be left over from the last run.
  assign halt_ok    = (state == RUN) && cpu_halted && (run_cnt >= CNT_W'(2));
  assign run_expire = (state == RUN) && !halt_ok && (run_cnt == CNT_W'(RUN_TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = in_addr;
          mem_wdata = in_data;
          if (in_last) state_nx = RUN;
        end
      end
      RUN: begin
        if (halt_ok)         state_nx = RD_REQ;
        else if (run_expire) state_nx = IDLE;
      end
      RD_REQ: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr;
        state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = out_last ? IDLE : RD_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cpu_run     <= 1'b0;
      run_cnt     <= '0;
      idx         <= '0;
      timeout_err <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      state   <= state_nx;
      cpu_run <= (state_nx == RUN);
      run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
      if (state == IDLE && start) timeout_err <= 1'b0;
      else if (run_expire)        timeout_err <= 1'b1;
      if (state == IDLE) idx <= '0;
      else if (state == SEND && out_ready && !out_last) idx <= idx + ADDR_W'(1);
      if (state == RD_WAIT) begin
        out_data <= mem_rdata;
        out_addr <= rd_addr;
        out_last <= (idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: shared memory plus a small core model,
// and a second instance with the result window straddling the top of memory.
module tb_mips_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        mem_we, mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        cpu_run;
  logic        cpu_halted = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last, busy, timeout_err;

  logic        w_start = 1'b0, w_in_valid = 1'b0, w_in_ready, w_in_last = 1'b0;
  logic [9:0]  w_in_addr = '0, w_mem_addr, w_out_addr;
  logic [31:0] w_in_data = '0, w_mem_wdata, w_out_data;
  logic [31:0] w_mem_rdata = '0;
  logic        w_mem_we, w_mem_re, w_cpu_run, w_out_valid, w_out_ready = 1'b0;
  logic        w_out_last, w_busy, w_timeout_err;
  logic        w_halted = 1'b1;

  int n_cmp = 0, n_bad = 0;
  int n_we = 0, n_re = 0, n_ov = 0;
  logic [41:0] exp_q[$];
  logic [41:0] e;
  logic [31:0] mem [0:1023];
  logic        prev_run = 1'b0;
  int          core_cnt = 0;
  int          core_mode = 0;   // 0: halts after a few cycles, 1: never halts

  mips_prog_loader dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  mips_prog_loader #(.DUMP_BASE(1023), .DUMP_LEN(2), .RUN_TIMEOUT(64)) dut_w (
    .clk1(clk1), .rst_n(rst_n), .start(w_start),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_addr(w_in_addr), .in_data(w_in_data), .in_last(w_in_last),
    .mem_we(w_mem_we), .mem_re(w_mem_re), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
    .cpu_run(w_cpu_run), .cpu_halted(w_halted),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_addr(w_out_addr), .out_data(w_out_data), .out_last(w_out_last),
    .busy(w_busy), .timeout_err(w_timeout_err)
  );

  // Clock and reset-free models
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory and core model: core clears HALTED when released, computes the result, halts.
  always @(posedge clk1) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    prev_run <= cpu_run;
    if (cpu_run && !prev_run) begin
      core_cnt   <= 0;
      cpu_halted <= 1'b0;
    end else if (cpu_run && core_mode == 0) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 8) begin
        mem[121]   <= mem[120] + 32'd45;
        cpu_halted <= 1'b1;
      end
    end
  end

  always @(posedge clk1) if (w_mem_re) w_mem_rdata <= {22'b0, w_mem_addr} + 32'h1000;

  // Scoreboard: every write must match the next expected (addr, data)
  always @(posedge clk1) if (rst_n) begin
    chk("we_re_excl", {31'b0, mem_we & mem_re}, 32'd0);
    if (mem_we) begin
      n_we++;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", {22'b0, mem_addr}, {22'b0, e[41:32]});
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (mem_re) n_re++;
    if (out_valid) n_ov++;
  end

  // Driver tasks, all entered and left on a falling edge
  task automatic do_start();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d, input logic l);
    in_valid = 1'b1; in_addr = a; in_data = d; in_last = l;
    exp_q.push_back({a, d});
    #1;
    chk("ld_ready", {31'b0, in_ready}, 32'd1);
    chk("ld_we", {31'b0, mem_we}, 32'd1);
    @(negedge clk1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_dump(input logic [9:0] ea, input logic [31:0] ed, input logic el, input int hold);
    int n = 0;
    int re0;
    while (!out_valid && n < 200) begin @(negedge clk1); n++; end
    chk("dump_valid", {31'b0, out_valid}, 32'd1);
    chk("dump_addr", {22'b0, out_addr}, {22'b0, ea});
    chk("dump_data", out_data, ed);
    chk("dump_last", {31'b0, out_last}, {31'b0, el});
    re0 = n_re;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", out_data, ed);
    end
    if (hold > 0) chk("bp_no_re", n_re, re0);
    out_ready = 1'b1;
    @(negedge clk1);
    out_ready = 1'b0;
  endtask

  int prog [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                   32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
  int we0, ov0, n;

  initial begin
    repeat (3) @(negedge clk1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_addr", {22'b0, out_addr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Reset in the middle of a load
    do_start();
    for (int i = 0; i < 3; i++) load_word(10'(500 + i), 32'hdead0000 + i, 1'b0);
    in_valid = 1'b1; in_addr = 10'd9; in_data = 32'h12345678;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_addr", {22'b0, mem_addr}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("midrst_writes", n_we, 3);

    // Program load, run, dump with backpressure on the first word
    do_start();
    chk("start_busy", {31'b0, busy}, 32'd1);
    we0 = n_we;
    for (int i = 0; i < 8; i++) load_word(10'(i), prog[i], 1'b0);
    chk("run_before_last", {31'b0, cpu_run}, 32'd0);
    load_word(10'd120, 32'd85, 1'b1);
    chk("run_after_last", {31'b0, cpu_run}, 32'd1);
    chk("load_writes", n_we - we0, 9);
    chk("load_q_empty", exp_q.size(), 0);
    get_dump(10'd120, 32'd85, 1'b0, 5);
    get_dump(10'd121, 32'd130, 1'b1, 0);
    chk("end_valid", {31'b0, out_valid}, 32'd0);
    chk("end_busy", {31'b0, busy}, 32'd0);

    // Halt left over from the previous run must not end this one early
    do_start();
    load_word(10'd120, 32'd200, 1'b1);
    chk("stale_halt_in", {31'b0, cpu_halted}, 32'd1);
    get_dump(10'd120, 32'd200, 1'b0, 0);
    get_dump(10'd121, 32'd245, 1'b1, 0);

    // Timeout: core never halts
    core_mode = 1;
    do_start();
    load_word(10'd7, 32'hfc000000, 1'b1);
    ov0 = n_ov;
    n = 0;
    while (cpu_run && n < 2000) begin n++; @(negedge clk1); end
    chk("to_cycles", n, 1024);
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    chk("to_cpu_run", {31'b0, cpu_run}, 32'd0);
    chk("to_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk1);
    chk("to_no_dump", n_ov, ov0);

    // Gapped input stream
    core_mode = 0;
    do_start();
    chk("to_cleared", {31'b0, timeout_err}, 32'd0);
    we0 = n_we;
    for (int i = 0; i < 3; i++) begin
      load_word(10'(20 + i), 32'hcafe0000 + i, 1'b0);
      #1;
      chk("gap_no_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk1);
    end
    load_word(10'd120, 32'd7, 1'b1);
    chk("gap_writes", n_we - we0, 4);
    get_dump(10'd120, 32'd7, 1'b0, 0);
    get_dump(10'd121, 32'd52, 1'b1, 0);

    // Window wrapping past the top of memory; halt held high throughout
    w_start = 1'b1;
    @(negedge clk1);
    w_start = 1'b0;
    w_in_valid = 1'b1; w_in_addr = 10'd3; w_in_data = 32'h1; w_in_last = 1'b1;
    @(negedge clk1);
    w_in_valid = 1'b0; w_in_last = 1'b0;
    n = 0;
    while (w_cpu_run && n < 100) begin n++; @(negedge clk1); end
    chk("w_run_cycles", n, 3);
    n = 0;
    while (!w_out_valid && n < 20) begin n++; @(negedge clk1); end
    chk("w_addr0", {22'b0, w_out_addr}, 32'd1023);
    chk("w_data0", w_out_data, 32'h13ff);
    chk("w_last0", {31'b0, w_out_last}, 32'd0);
    w_out_ready = 1'b1;
    @(negedge clk1);
    w_out_ready = 1'b0;
    n = 0;
    while (!w_out_valid && n < 20) begin n++; @(negedge clk1); end
    chk("w_addr1", {22'b0, w_out_addr}, 32'd0);
    chk("w_data1", w_out_data, 32'h1000);
    chk("w_last1", {31'b0, w_out_last}, 32'd1);
    w_out_ready = 1'b1;
    @(negedge clk1);
    w_out_ready = 1'b0;
    chk("w_idle", {31'b0, w_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
